// File: rtl/backing_ram.sv
// backing_ram: word-addressed backing store behind a cache. Accepts single
// write-through writes and block-fill reads. A read returns a whole block as
// a critical-word-first burst after a fixed access latency.
//
// Ports:
//   clk             - single clock, all state on rising edge
//   reset           - asynchronous, active-high reset
//   miss            - block-fill read request
//   prop_address    - word address of the request
//   prop_write_data - write-through data
//   prop_write_en   - write request (wins over a simultaneous miss)
//   ready           - high only while idle; request accepted when high
//   fill_data       - burst beat data
//   fill_valid      - fill_data valid this cycle
//   fill_offset     - word offset within the block of the current beat
//   fill_last       - final beat of the burst
module backing_ram #(
   parameter int RAM_ADDRESS_BITS = 10,
   parameter int DATA_WIDTH       = 32,
   parameter int BLOCK_BITS       = 2,
   parameter int LATENCY          = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        miss,
   input  logic [RAM_ADDRESS_BITS-1:0] prop_address,
   input  logic [DATA_WIDTH-1:0]       prop_write_data,
   input  logic                        prop_write_en,
   output logic                        ready,
   output logic [DATA_WIDTH-1:0]       fill_data,
   output logic                        fill_valid,
   output logic [BLOCK_BITS-1:0]       fill_offset,
   output logic                        fill_last
);

   localparam int WORDS = 1 << RAM_ADDRESS_BITS;
   localparam int TAG_BITS = RAM_ADDRESS_BITS - BLOCK_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      WAIT,
      BURST
   } state_t;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   state_t state;
   state_t state_next;
   logic [3:0] count;
   logic [3:0] count_next;

   // The block base is kept as its upper bits only; the beat address is
   // formed by concatenation, so offsets wrap inside the block and can never
   // carry into the neighbouring block.
   logic [TAG_BITS-1:0]   base_tag;
   logic [BLOCK_BITS-1:0] offset;
   logic [BLOCK_BITS-1:0] beat_count;

   logic accept_write;
   logic accept_read;
   logic last_beat;

   assign ready        = (state == IDLE);
   assign accept_write = ready & prop_write_en;
   assign accept_read  = ready & miss & ~prop_write_en;
   assign last_beat    = (beat_count == '1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      unique case (state)
         IDLE: begin
            if (accept_write) begin
               state_next = WRITE;
            end else if (accept_read) begin
               state_next = WAIT;
               count_next = WAIT_LOAD;
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = BURST;
            end else begin
               count_next = count - 4'd1;
            end
         end
         BURST: begin
            if (last_beat) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Storage has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (accept_write) begin
         mem[prop_address] <= prop_write_data;
      end
   end

   // Beats are registered: each edge spent in BURST launches one beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_tag    <= '0;
         offset      <= '0;
         beat_count  <= '0;
         fill_data   <= '0;
         fill_valid  <= 1'b0;
         fill_offset <= '0;
         fill_last   <= 1'b0;
      end else begin
         fill_valid <= 1'b0;
         fill_last  <= 1'b0;
         if (accept_read) begin
            base_tag   <= prop_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
            offset     <= prop_address[BLOCK_BITS-1:0];
            beat_count <= '0;
         end
         if (state == BURST) begin
            fill_valid  <= 1'b1;
            fill_data   <= mem[{base_tag, offset}];
            fill_offset <= offset;
            fill_last   <= last_beat;
            offset      <= offset + 1'b1;
            beat_count  <= beat_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_backing_ram.sv
// tb_backing_ram: randomized scoreboard bench for backing_ram.
// Driver pushes expected beats; a negedge monitor pops and compares.
module tb_backing_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        miss = 1'b0;
   logic [9:0]  prop_address = '0;
   logic [31:0] prop_write_data = '0;
   logic        prop_write_en = 1'b0;
   logic        ready;
   logic [31:0] fill_data;
   logic        fill_valid;
   logic [1:0]  fill_offset;
   logic        fill_last;

   backing_ram dut (
      .clk(clk),
      .reset(reset),
      .miss(miss),
      .prop_address(prop_address),
      .prop_write_data(prop_write_data),
      .prop_write_en(prop_write_en),
      .ready(ready),
      .fill_data(fill_data),
      .fill_valid(fill_valid),
      .fill_offset(fill_offset),
      .fill_last(fill_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  off;
      logic        last;
      int          at;
   } beat_t;

   beat_t       q[$];
   logic [31:0] mdl [1024];
   int          free_at = 0;
   int          vectors = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      beat_t b;
      if (!reset) begin
         if (fill_valid) begin
            if (q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_beat: got data %0h off %0d expected none",
                        fill_data, fill_offset);
            end else begin
               b = q.pop_front();
               chk("beat_cycle", cyc, b.at);
               chk("beat_data", fill_data, b.d);
               chk("beat_offset", fill_offset, b.off);
               chk("beat_last", fill_last, b.last);
            end
         end else begin
            chk("idle_last", fill_last, 0);
            if (q.size() > 0 && cyc > q[0].at) begin
               b = q.pop_front();
               vectors++;
               errors++;
               $display("FAIL missing_beat: got none expected data %0h at cycle %0d",
                        b.d, b.at);
            end
         end
      end
   end

   task automatic junk(input bit hold_miss);
      miss = hold_miss ? 1'b1 : 1'($urandom);
      prop_write_en = 1'($urandom);
      prop_address = 10'($urandom);
      prop_write_data = $urandom;
   endtask

   task automatic wait_ready(input bit hold_miss);
      while (cyc < free_at) begin
         chk("ready_busy", ready, 0);
         junk(hold_miss);
         @(negedge clk);
      end
      chk("ready_idle", ready, 1);
   endtask

   task automatic do_write(input logic [9:0] a, input logic [31:0] d);
      wait_ready(0);
      miss = 1'b0;
      prop_write_en = 1'b1;
      prop_address = a;
      prop_write_data = d;
      mdl[a] = d;
      free_at = cyc + 2;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [9:0] a, input bit hold);
      int c0;
      beat_t b;
      logic [9:0] base;
      wait_ready(hold);
      miss = 1'b1;
      prop_write_en = 1'b0;
      prop_address = a;
      prop_write_data = $urandom;
      c0 = cyc + 1;
      base = a & 10'h3FC;
      for (int i = 0; i < 4; i++) begin
         b.off = 2'((int'(a) + i) % 4);
         b.d = mdl[base | 10'(b.off)];
         b.last = (i == 3);
         b.at = c0 + 5 + i;
         q.push_back(b);
      end
      free_at = c0 + 8;
      @(negedge clk);
   endtask

   // Miss and write together: write wins, miss is held until accepted.
   task automatic do_both(input logic [9:0] a, input logic [31:0] d);
      wait_ready(0);
      miss = 1'b1;
      prop_write_en = 1'b1;
      prop_address = a;
      prop_write_data = d;
      mdl[a] = d;
      free_at = cyc + 2;
      @(negedge clk);
      do_read(a, 1);
   endtask

   task automatic go_quiet();
      miss = 1'b0;
      prop_write_en = 1'b0;
   endtask

   initial begin
      int c0;
      int op;
      logic [9:0] a;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_valid", fill_valid, 0);
      chk("rst_last", fill_last, 0);
      chk("rst_data", fill_data, 0);
      chk("rst_offset", fill_offset, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      free_at = cyc;
      @(negedge clk);

      for (int i = 0; i < 1024; i++) do_write(10'(i), $urandom);

      for (int i = 0; i < 4; i++) do_write(10'h010 + 10'(i), 32'hAAAA0000 + i);
      do_read(10'h010, 0);
      do_read(10'h012, 0);
      do_write(10'h3FC, 32'h11);
      do_write(10'h3FD, 32'h22);
      do_write(10'h3FE, 32'h33);
      do_write(10'h3FF, 32'h44);
      do_read(10'h3FF, 0);
      do_both(10'h020, 32'hDEADBEEF);

      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 3);
         a = ($urandom_range(0, 3) == 0) ? 10'h3FC | 10'($urandom_range(0, 3))
                                         : 10'($urandom);
         case (op)
            0: do_write(a, $urandom);
            1: do_read(a, 0);
            2: do_both(a, $urandom);
            default: begin
               wait_ready(0);
               go_quiet();
               @(negedge clk);
            end
         endcase
      end

      // Reset while the second beat is on the bus.
      do_read(10'h100, 0);
      c0 = free_at - 8;
      while (cyc < c0 + 6) begin
         junk(0);
         @(negedge clk);
      end
      go_quiet();
      #2;
      reset = 1'b1;
      #1;
      chk("abort_valid", fill_valid, 0);
      chk("abort_ready", ready, 1);
      chk("abort_last", fill_last, 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      free_at = cyc;
      repeat (12) @(negedge clk);
      do_write(10'h040, 32'h5);
      do_read(10'h040, 0);

      go_quiet();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         vectors++;
         errors++;
         $display("FAIL drain: got %0d beats pending expected 0", q.size());
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/backing_ram.md
BACKING_RAM -- requirements
Module: backing_ram

Interface
REQ-001 Parameter RAM_ADDRESS_BITS, default 10, word-address width of backing store (2^RAM_ADDRESS_BITS words).
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Parameter BLOCK_BITS, default 2, log2 words per cache block (burst length 2^BLOCK_BITS).
REQ-004 Parameter LATENCY, default 4, idle cycles between read acceptance and first beat; legal range 1..15.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port miss  input  1  block-fill read request from cache.
REQ-008 Port prop_address  input  RAM_ADDRESS_BITS  word address of read or write request.
REQ-009 Port prop_write_data  input  DATA_WIDTH  write-through data.
REQ-010 Port prop_write_en  input  1  write request from cache.
REQ-011 Port ready  output  1  request acceptance; high only in IDLE.
REQ-012 Port fill_data  output  DATA_WIDTH  burst beat data.
REQ-013 Port fill_valid  output  1  fill_data valid this cycle.
REQ-014 Port fill_offset  output  BLOCK_BITS  word offset within block of current beat.
REQ-015 Port fill_last  output  1  final beat of burst.

Function
REQ-016 States SHALL be IDLE, WRITE, WAIT, BURST; encoding free.
REQ-017 ready SHALL be combinationally 1 in IDLE, 0 in all other states.
REQ-018 A request is accepted on a rising edge where ready=1 and (miss=1 or prop_write_en=1).
REQ-019 Write accept: mem[prop_address] <= prop_write_data on the accepting edge; IDLE->WRITE; WRITE->IDLE unconditionally next edge (ready low exactly 1 cycle).
REQ-020 Simultaneous miss and prop_write_en in IDLE: write SHALL win; read not accepted; cache holds miss, accepted on first edge after return to IDLE.
REQ-021 Read accept: latch block base (prop_address with low BLOCK_BITS cleared) and start offset (low BLOCK_BITS of prop_address); IDLE->WAIT; load wait counter with LATENCY-1.
REQ-022 WAIT: decrement counter each edge; at 0 go to BURST; first beat (fill_valid=1) appears LATENCY+1 cycles after the accepting edge.
REQ-023 BURST: exactly 2^BLOCK_BITS consecutive beats, one per cycle, critical-word first: offsets start, start+1, ... modulo 2^BLOCK_BITS (wrap within block, never into adjacent block).
REQ-024 Each beat: fill_data = mem[base | fill_offset], registered (valid in same cycle as fill_valid), fill_offset = current offset.
REQ-025 fill_last=1 only on the 2^BLOCK_BITS-th beat; BURST->IDLE on that edge; ready=1 the following cycle.
REQ-026 miss and prop_write_en SHALL be ignored outside IDLE; prop_address/prop_write_data need be stable only on the accepting edge.
REQ-027 Outside BURST: fill_valid=0, fill_last=0, fill_data and fill_offset hold last value.
REQ-028 Address arithmetic: block base + offset SHALL not carry into upper bits; top-of-memory block (base 0x3FC, default params) SHALL wrap offsets 3->0 within 0x3FC..0x3FF.

Reset
REQ-029 On reset=1 asynchronously: state IDLE, ready=1, fill_valid=0, fill_last=0, fill_data=0, fill_offset=0, wait counter=0.
REQ-030 Memory array SHALL not be cleared by reset; contents undefined until written.
REQ-031 Reset mid-WAIT or mid-BURST SHALL abort the burst: no further beats after reset deasserts; next request accepted normally.

Verification
REQ-032 Write 0xAAAA0000+i to addresses 0x010..0x013, then miss with prop_address=0x010 -> ready low 1 cycle per write; after read accept, first beat at cycle 5, beats 0xAAAA0000..0xAAAA0003, offsets 0,1,2,3, fill_last on 4th.
REQ-033 Same data, miss with prop_address=0x012 -> beats offsets 2,3,0,1, data 0xAAAA0002,0xAAAA0003,0xAAAA0000,0xAAAA0001.
REQ-034 Write 0x11,0x22,0x33,0x44 to 0x3FC..0x3FF, miss at 0x3FF -> beats 0x44,0x11,0x22,0x33; no access outside 0x3FC..0x3FF.
REQ-035 miss=1 and prop_write_en=1 same edge, address 0x020, data 0xDEADBEEF -> write performed, then read accepted next IDLE edge; burst offset 0 returns 0xDEADBEEF.
REQ-036 Assert reset during 2nd burst beat -> fill_valid=0 immediately, ready=1; no beats after deassertion; subsequent write/read of 0x040=0x5 returns 0x5.
REQ-037 miss pulsed during WAIT/BURST, prop_write_en during BURST -> ignored; memory unchanged, beat count exactly 4.
